mem_responder: RTL and testbench

//   Memory-side end of the control unit's mem_rd/mem_wr bus protocol: single-port word RAM

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 91 +++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the control unit (master) and the word RAM (slave).
// The master holds mem_rd or mem_wr until it sees ack.
interface mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ack;
    logic                  err;
    logic                  busy;

    modport master (
        output mem_rd, mem_wr, addr, wr_data,
        input  rd_data, ack, err, busy
    );

    modport slave (
        input  mem_rd, mem_wr, addr, wr_data,
        output rd_data, ack, err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word RAM answering mem_rd/mem_wr requests after a programmable number of
// wait states, with one-cycle ack/err pulses and a registered busy flag.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

    state_e                state_q;
    logic [7:0]            cnt_q;
    logic                  op_wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic [IdxWidth-1:0]   idx;

    assign in_range = 64'(addr_q) < 64'(DEPTH);
    assign idx      = addr_q[IdxWidth-1:0];

    // RAM contents are deliberately left out of the reset branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A request still held during the ack cycle must not start a new access.
                    if (!ack_q) begin
                        if (bus.mem_rd ^ bus.mem_wr) begin
                            op_wr_q <= bus.mem_wr;
                            addr_q  <= bus.addr;
                            wdata_q <= bus.wr_data;
                            cnt_q   <= 8'(WAIT_STATES);
                            busy_q  <= 1'b1;
                            state_q <= (WAIT_STATES > 0) ? StWait : StAccess;
                        end else if (bus.mem_rd && bus.mem_wr) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    ack_q   <= 1'b1;
                    err_q   <= !in_range;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                    if (op_wr_q) begin
                        if (in_range) begin
                            mem[idx] <= wdata_q;
                        end
                    end else begin
                        rd_data_q <= in_range ? mem[idx] : '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: per-cycle comparison against a transaction-level model of the
// WAIT_STATES=2 instance, plus directed checks on both instances.
module tb_mem_responder;
    localparam int unsigned Ws    = 2;
    localparam int unsigned Depth = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();
    mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();

    mem_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(Depth), .WAIT_STATES(Ws)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    mem_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(Depth), .WAIT_STATES(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted access completes WAIT_STATES+1 edges later.
    logic [31:0] m_mem   [Depth];
    bit          m_known [Depth];
    int          edge_n = 0;
    bit          m_pend = 1'b0;
    int          m_done = 0;
    bit          m_op_wr;
    int unsigned m_addr;
    logic [31:0] m_data;
    bit          m_ack = 1'b0, m_err = 1'b0, m_busy = 1'b0, m_rd_known = 1'b1;
    logic [31:0] m_rd = '0;

    always @(posedge clk) begin
        bit prev_ack;
        bit oor;
        edge_n++;
        prev_ack = m_ack;
        if (rst) begin
            m_pend = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_busy = 1'b0;
            m_rd = '0; m_rd_known = 1'b1;
        end else begin
            m_ack = 1'b0;
            m_err = 1'b0;
            if (m_pend) begin
                if (edge_n == m_done) begin
                    oor = (m_addr >= Depth);
                    m_pend = 1'b0; m_busy = 1'b0; m_ack = 1'b1; m_err = oor;
                    if (m_op_wr) begin
                        if (!oor) begin
                            m_mem[m_addr] = m_data;
                            m_known[m_addr] = 1'b1;
                        end
                    end else if (oor) begin
                        m_rd = '0; m_rd_known = 1'b1;
                    end else begin
                        m_rd = m_mem[m_addr]; m_rd_known = m_known[m_addr];
                    end
                end
            end else if (!prev_ack) begin
                if (bus.mem_rd != bus.mem_wr) begin
                    m_pend = 1'b1; m_done = edge_n + Ws + 1; m_busy = 1'b1;
                    m_op_wr = bus.mem_wr; m_addr = bus.addr; m_data = bus.wr_data;
                end else if (bus.mem_rd && bus.mem_wr) begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("ack", 32'(bus.ack), 32'(m_ack));
            chk("err", 32'(bus.err), 32'(m_err));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            if (m_rd_known) chk("rd_data", bus.rd_data, m_rd);
        end
    end

    // Called at a negedge; returns at a negedge after ack (plus hold extra cycles).
    task automatic do_op(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] d,
                         input int hold, output logic [31:0] rdata, output bit got_err,
                         output int lat, output int busy_n);
        bit done = 1'b0;
        lat = 0; busy_n = 0; got_err = 1'b0; rdata = '0;
        bus.mem_rd = rd; bus.mem_wr = wr; bus.addr = a; bus.wr_data = d;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            if (bus.ack) begin
                done = 1'b1; rdata = bus.rd_data; got_err = bus.err;
            end
        end
        if (!done) chk("ack_timeout", 32'(lat), 32'(0));
        repeat (hold) @(negedge clk);
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
    endtask

    task automatic wait_ack0(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus0.ack && lat < 50);
        if (!bus0.ack) chk("ack0_timeout", 32'(lat), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        bit          e;
        int          lat, busy_n, acks;
        logic [15:0] a;

        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.addr = '0; bus.wr_data = '0;
        bus0.mem_rd = 1'b0; bus0.mem_wr = 1'b0; bus0.addr = '0; bus0.wr_data = '0;
        repeat (3) @(negedge clk);
        foreach (m_known[i]) m_known[i] = 1'b0;
        chk("rst_ack", 32'(bus.ack), 32'(0));
        chk("rst_err", 32'(bus.err), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst0_busy", 32'(bus0.busy), 32'(0));
        rst = 1'b0;
        check_en = 1'b1;

        // Write with two wait states.
        do_op(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 0, rdata, e, lat, busy_n);
        chk("t1_latency", 32'(lat), 32'(4));
        chk("t1_err", 32'(e), 32'(0));
        chk("t1_busy_cycles", 32'(busy_n), 32'(3));
        repeat (2) @(negedge clk);

        // Read back, request held one cycle past ack.
        do_op(1'b1, 1'b0, 16'h0010, 32'h0, 1, rdata, e, lat, busy_n);
        chk("t2_rd_data", rdata, 32'hDEADBEEF);
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack || bus.busy) acks++;
        end
        chk("t2_no_reaccess", 32'(acks), 32'(0));

        // Both requests at once.
        bus.mem_rd = 1'b1; bus.mem_wr = 1'b1; bus.addr = 16'h0010; bus.wr_data = 32'h0BAD0BAD;
        @(negedge clk);
        chk("t3_err", 32'(bus.err), 32'(1));
        chk("t3_ack", 32'(bus.ack), 32'(0));
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
        @(negedge clk);
        chk("t3_err_pulse", 32'(bus.err), 32'(0));
        @(negedge clk);
        do_op(1'b1, 1'b0, 16'h0010, 32'h0, 0, rdata, e, lat, busy_n);
        chk("t3_ram_unchanged", rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Out-of-range accesses.
        do_op(1'b0, 1'b1, 16'h0000, 32'hA5A50000, 0, rdata, e, lat, busy_n);
        @(negedge clk);
        do_op(1'b0, 1'b1, 16'(Depth), 32'h77777777, 0, rdata, e, lat, busy_n);
        chk("t4_wr_oor_err", 32'(e), 32'(1));
        @(negedge clk);
        do_op(1'b1, 1'b0, 16'(Depth), 32'h0, 0, rdata, e, lat, busy_n);
        chk("t4_rd_oor_data", rdata, 32'h0);
        chk("t4_rd_oor_err", 32'(e), 32'(1));
        @(negedge clk);
        do_op(1'b1, 1'b0, 16'h0000, 32'h0, 0, rdata, e, lat, busy_n);
        chk("t4_addr0", rdata, 32'hA5A50000);
        @(negedge clk);

        // Reset during the wait phase of a write.
        do_op(1'b0, 1'b1, 16'h0020, 32'hCAFE0020, 0, rdata, e, lat, busy_n);
        repeat (2) @(negedge clk);
        bus.mem_wr = 1'b1; bus.addr = 16'h0020; bus.wr_data = 32'h12345678;
        @(negedge clk);
        chk("t5_busy_before", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        bus.mem_wr = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(bus.busy), 32'(0));
        chk("t5_ack", 32'(bus.ack), 32'(0));
        rst = 1'b0;
        repeat (6) @(negedge clk);
        do_op(1'b1, 1'b0, 16'h0020, 32'h0, 0, rdata, e, lat, busy_n);
        chk("t5_old_value", rdata, 32'hCAFE0020);
        @(negedge clk);

        // Zero wait states on the second instance.
        bus0.mem_wr = 1'b1; bus0.addr = 16'h0001; bus0.wr_data = 32'h11110001;
        wait_ack0(lat);
        chk("t6_wr_latency", 32'(lat), 32'(2));
        bus0.mem_wr = 1'b0;
        @(negedge clk);
        bus0.mem_wr = 1'b1; bus0.addr = 16'h0002; bus0.wr_data = 32'h22220002;
        wait_ack0(lat);
        bus0.mem_wr = 1'b0;
        @(negedge clk);
        bus0.mem_rd = 1'b1; bus0.addr = 16'h0001;
        wait_ack0(lat);
        chk("t6_rd1_latency", 32'(lat), 32'(2));
        chk("t6_rd1_data", bus0.rd_data, 32'h11110001);
        // Keep mem_rd asserted: the next read is accepted on the edge after the ack cycle.
        bus0.addr = 16'h0002;
        wait_ack0(lat);
        chk("t6_rd2_spacing", 32'(lat), 32'(3));
        chk("t6_rd2_data", bus0.rd_data, 32'h22220002);
        bus0.mem_rd = 1'b0;
        @(negedge clk);

        // Randomised traffic against the model.
        for (int n = 0; n < 150; n++) begin
            int sel;
            int asel;
            asel = int'($urandom_range(0, 7));
            case (asel)
                0:       a = 16'(Depth - 1);
                1:       a = 16'(Depth);
                2:       a = 16'($urandom);
                default: a = 16'($urandom_range(0, 15));
            endcase
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                bus.mem_rd = 1'b1; bus.mem_wr = 1'b1; bus.addr = a; bus.wr_data = $urandom;
                @(negedge clk);
                bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
            end else begin
                do_op(sel < 5, sel >= 5, a, $urandom, int'($urandom_range(0, 1)),
                      rdata, e, lat, busy_n);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
